// File: rtl/load_store_unit.sv
// Load/store unit: turns one byte/half/word access into one or two
// word-aligned bus cycles, merging load data and extending the result.
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  mem_width,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned DW  = 32;
  localparam int unsigned LW  = 64;
  localparam int unsigned BEW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC1 = 2'd1,
    ACC2 = 2'd2,
    RESP = 2'd3
  } state_e;

  // Byte-lane mask across two adjacent words for size code and offset.
  function automatic logic [7:0] lane_mask(input logic [1:0] sz, input logic [1:0] off);
    logic [7:0] base;
    case (sz)
      2'b00:   base = 8'h01;
      2'b01:   base = 8'h03;
      default: base = 8'h0F;
    endcase
    return base << off;
  endfunction

  // Store data placed on its byte lanes across two words.
  function automatic logic [LW-1:0] store_shift(input logic [DW-1:0] d, input logic [1:0] off);
    return {32'h0, d} << {off, 3'b000};
  endfunction

  // Select the addressed bytes of the merged load data and extend them.
  function automatic logic [DW-1:0] load_extend(input logic [LW-1:0] l, input logic [1:0] off,
                                                input logic [2:0] w);
    logic [DW-1:0] sh;
    sh = 32'(l >> {off, 3'b000});
    case (w[1:0])
      2'b00:   return w[2] ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   return w[2] ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  state_e          state_q, state_d;
  logic            we_q, we_d;
  logic [2:0]      width_q, width_d;
  logic [1:0]      off_q, off_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            bus_req_q, bus_req_d;
  logic            bus_we_q, bus_we_d;
  logic [DW-1:0]   bus_addr_q, bus_addr_d;
  logic [BEW-1:0]  bus_be_q, bus_be_d;
  logic [DW-1:0]   bus_wdata_q, bus_wdata_d;
  logic            resp_valid_q, resp_valid_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [LW-1:0]   l_q, l_d;

  logic [BEW-1:0]  new_be_c;
  logic [DW-1:0]   new_wdata_c;
  logic [BEW-1:0]  cap_be_hi_c;
  logic [DW-1:0]   cap_wdata_hi_c;
  logic            split_c;
  logic            done_c;

  // Lane/data views of the incoming request and of the captured request.
  assign new_be_c       = 4'(lane_mask(mem_width[1:0], addr[1:0]));
  assign new_wdata_c    = 32'(store_shift(wdata, addr[1:0]));
  assign cap_be_hi_c    = 4'(lane_mask(width_q[1:0], off_q) >> 4);
  assign cap_wdata_hi_c = 32'(store_shift(wdata_q, off_q) >> 32);
  assign split_c        = |cap_be_hi_c;

  assign req_ready  = (state_q == IDLE) && !reset;
  assign resp_valid = resp_valid_q;
  assign rdata      = rdata_q;
  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_be     = bus_be_q;
  assign bus_wdata  = bus_wdata_q;

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    width_d      = width_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_be_d     = bus_be_q;
    bus_wdata_d  = bus_wdata_q;
    resp_valid_d = 1'b0;
    rdata_d      = rdata_q;
    l_d          = l_q;
    done_c       = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d        = req_we;
          width_d     = mem_width;
          off_d       = addr[1:0];
          wdata_d     = wdata;
          bus_req_d   = 1'b1;
          bus_we_d    = req_we;
          bus_addr_d  = {addr[31:2], 2'b00};
          bus_be_d    = new_be_c;
          bus_wdata_d = req_we ? new_wdata_c : 32'h0;
          state_d     = ACC1;
        end
      end
      ACC1: begin
        if (bus_ack) begin
          if (!we_q) l_d[31:0] = bus_rdata;
          if (split_c) begin
            bus_addr_d  = bus_addr_q + 32'd4;
            bus_be_d    = cap_be_hi_c;
            bus_wdata_d = we_q ? cap_wdata_hi_c : 32'h0;
            state_d     = ACC2;
          end else begin
            done_c = 1'b1;
          end
        end
      end
      ACC2: begin
        if (bus_ack) begin
          if (!we_q) l_d[63:32] = bus_rdata;
          done_c = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Closing the bus access: drop the bus and present the result.
    if (done_c) begin
      bus_req_d    = 1'b0;
      bus_we_d     = 1'b0;
      bus_addr_d   = 32'h0;
      bus_be_d     = 4'h0;
      bus_wdata_d  = 32'h0;
      resp_valid_d = 1'b1;
      rdata_d      = we_q ? 32'h0 : load_extend(l_d, off_q, width_q);
      state_d      = RESP;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      width_q      <= 3'b000;
      off_q        <= 2'b00;
      wdata_q      <= 32'h0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= 32'h0;
      bus_be_q     <= 4'h0;
      bus_wdata_q  <= 32'h0;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'h0;
      l_q          <= 64'h0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      width_q      <= width_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_be_q     <= bus_be_d;
      bus_wdata_q  <= bus_wdata_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      l_q          <= l_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized bench for load_store_unit with an arithmetic reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  mem_width;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int n_cmp = 0;
  int n_err = 0;

  load_store_unit dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .mem_width  (mem_width),
    .addr       (addr),
    .wdata      (wdata),
    .resp_valid (resp_valid),
    .rdata      (rdata),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete access; expected bus cycles and result derived from byte arithmetic.
  task automatic access(input bit we, input logic [2:0] w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] r1, input logic [31:0] r2,
                        input int st1, input int st2);
    int          n, o, mi, lat, cyc;
    logic [3:0]  be1, be2;
    logic [31:0] a1, a2, exp_rd;
    logic [63:0] s, ld, lim, v;
    bit          split;
    n     = (w[1:0] == 2'b00) ? 1 : (w[1:0] == 2'b01) ? 2 : 4;
    o     = int'(a[1:0]);
    mi    = ((1 << n) - 1) << o;
    be1   = 4'(mi & 15);
    be2   = 4'((mi >> 4) & 15);
    split = (be2 != 4'h0);
    a1    = a & 32'hFFFF_FFFC;
    a2    = a1 + 32'd4;
    s     = 64'(wd) * (64'd1 << (8 * o));
    ld    = {r2, r1};
    lim   = (64'd1 << (8 * n));
    v     = (ld / (64'd1 << (8 * o))) % lim;
    if (!w[2] && v >= (lim >> 1)) v = v + (64'hFFFF_FFFF_FFFF_FFFF - lim + 64'd1);
    exp_rd = we ? 32'h0 : v[31:0];
    lat    = 2 + (split ? 1 : 0) + st1 + (split ? st2 : 0);

    check("ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_we = we; mem_width = w; addr = a; wdata = wd;
    step();
    cyc = 1;
    req_valid = 1'b0; req_we = 1'($urandom); mem_width = 3'($urandom);
    addr = $urandom; wdata = $urandom;

    for (int k = 0; k <= st1; k++) begin
      check("acc1_req", 64'(bus_req), 64'd1);
      check("acc1_addr", 64'(bus_addr), 64'(a1));
      check("acc1_be", 64'(bus_be), 64'(be1));
      check("acc1_we", 64'(bus_we), 64'(we));
      if (we) check("acc1_wdata", 64'(bus_wdata), s[31:0]);
      check("acc1_no_resp", 64'(resp_valid), 64'd0);
      check("acc1_not_ready", 64'(req_ready), 64'd0);
      bus_ack = (k == st1);
      bus_rdata = (k == st1) ? r1 : $urandom;
      step();
      cyc++;
      bus_ack = 1'b0; bus_rdata = $urandom;
    end

    if (split) begin
      for (int k = 0; k <= st2; k++) begin
        check("acc2_req", 64'(bus_req), 64'd1);
        check("acc2_addr", 64'(bus_addr), 64'(a2));
        check("acc2_be", 64'(bus_be), 64'(be2));
        check("acc2_we", 64'(bus_we), 64'(we));
        if (we) check("acc2_wdata", 64'(bus_wdata), s[63:32]);
        check("acc2_no_resp", 64'(resp_valid), 64'd0);
        bus_ack = (k == st2);
        bus_rdata = (k == st2) ? r2 : $urandom;
        step();
        cyc++;
        bus_ack = 1'b0; bus_rdata = $urandom;
      end
    end

    check("resp_latency", 64'(cyc), 64'(lat));
    check("resp_valid", 64'(resp_valid), 64'd1);
    check("resp_rdata", 64'(rdata), 64'(exp_rd));
    check("resp_bus_req", 64'(bus_req), 64'd0);
    check("resp_not_ready", 64'(req_ready), 64'd0);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    check("after_resp_pulse", 64'(resp_valid), 64'd0);
    check("after_resp_hold", 64'(rdata), 64'(exp_rd));
    check("after_resp_no_accept", 64'(bus_req), 64'd0);
  endtask

  initial begin
    logic [2:0]  wsel [5];
    logic [31:0] ra;
    wsel[0] = 3'b000; wsel[1] = 3'b001; wsel[2] = 3'b010; wsel[3] = 3'b100; wsel[4] = 3'b101;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; mem_width = 3'b000;
    addr = 32'h0; wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;

    #1;
    check("ready_in_reset", 64'(req_ready), 64'd0);
    step();
    step();
    check("ready_in_reset2", 64'(req_ready), 64'd0);
    reset = 1'b0;
    #1;
    check("rst_bus_req", 64'(bus_req), 64'd0);
    check("rst_bus_addr", 64'(bus_addr), 64'd0);
    check("rst_bus_be", 64'(bus_be), 64'd0);
    check("rst_bus_wdata", 64'(bus_wdata), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);

    // Directed cases.
    access(1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 32'h0, 0, 0);
    check("lw_value", 64'(rdata), 64'h0000_0000_DEAD_BEEF);
    access(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h8000_0000, 32'h0, 0, 0);
    check("lb_value", 64'(rdata), 64'h0000_0000_FFFF_FF80);
    access(1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h8000_0000, 32'h0, 0, 0);
    check("lbu_value", 64'(rdata), 64'h0000_0000_0000_0080);
    access(1'b1, 3'b010, 32'h0000_0102, 32'hAABB_CCDD, 32'h0, 32'h0, 0, 0);
    check("sw_split_rdata", 64'(rdata), 64'h0);
    access(1'b0, 3'b001, 32'hFFFF_FFFF, 32'h0, 32'h1200_0000, 32'h0000_0034, 0, 0);
    check("lh_wrap_value", 64'(rdata), 64'h0000_0000_0000_3412);
    access(1'b0, 3'b010, 32'h0000_0201, 32'h0, 32'h4433_2211, 32'h8877_6655, 3, 2);

    // Stall in ACC1, then reset with a coincident ack.
    req_valid = 1'b1; req_we = 1'b0; mem_width = 3'b010; addr = 32'h0000_0300;
    step();
    req_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("stall_req", 64'(bus_req), 64'd1);
      check("stall_addr", 64'(bus_addr), 64'h300);
      check("stall_be", 64'(bus_be), 64'hF);
      bus_rdata = $urandom;
      step();
    end
    reset = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
    #1;
    check("stall_rst_ready", 64'(req_ready), 64'd0);
    step();
    reset = 1'b0; bus_ack = 1'b0;
    #1;
    check("abort_bus_req", 64'(bus_req), 64'd0);
    check("abort_resp", 64'(resp_valid), 64'd0);
    check("abort_rdata", 64'(rdata), 64'd0);
    check("abort_ready", 64'(req_ready), 64'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      check("abort_no_resp", 64'(resp_valid), 64'd0);
      check("abort_idle_bus", 64'(bus_req), 64'd0);
    end

    // Randomized accesses, with addresses sometimes near the wrap point.
    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      access(1'($urandom), wsel[$urandom_range(0, 4)], ra, $urandom, $urandom, $urandom,
             $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-003 The block SHALL have: req_valid  in  1  access request present.
REQ-004 The block SHALL have: req_ready  out  1  block can accept a request.
REQ-005 The block SHALL have: req_we  in  1  1 = store, 0 = load.
REQ-006 The block SHALL have: mem_width  in  3  funct3-encoded width (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-007 The block SHALL have: addr  in  32  byte address; wdata  in  32  store data in bits [8n-1:0].
REQ-008 The block SHALL have: resp_valid  out  1  one-cycle completion pulse; rdata  out  32  extended load result.
REQ-009 The block SHALL have: bus_req  out  1; bus_we  out  1; bus_addr  out  32 (word-aligned, [1:0]=00); bus_be  out  4; bus_wdata  out  32.
REQ-010 The block SHALL have: bus_ack  in  1  access done; bus_rdata  in  32  read data, valid while bus_ack=1.

Function
REQ-011 The block SHALL implement the states IDLE, ACC1, ACC2 and RESP.
REQ-012 req_ready SHALL be 1 only in IDLE with reset low; a request SHALL be accepted on the edge where req_valid&req_ready=1, capturing req_we, mem_width, addr and wdata.
REQ-013 The access size n SHALL be 1 for mem_width[1:0]=00, 2 for 01, and 4 for 10 or 11; mem_width[2]=1 SHALL select zero-extension, otherwise sign-extension.
REQ-014 With o=addr[1:0], the 8-bit lane mask SHALL be m=((1<<n)-1)<<o.
REQ-015 ACC1 SHALL drive bus_addr={addr[31:2],2'b00} and bus_be=m[3:0].
REQ-016 ACC2 SHALL be entered only when m[7:4]!=0; it SHALL drive bus_addr=ACC1 address+4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000), and bus_be=m[7:4].
REQ-017 For stores, the 64-bit value S=wdata<<(8*o) SHALL supply bus_wdata=S[31:0] in ACC1 and S[63:32] in ACC2; bus_we SHALL equal the captured req_we in both states.
REQ-018 bus_req and all bus outputs SHALL be registered, asserted from the cycle after acceptance, and held stable until bus_ack=1 is sampled.
REQ-019 From ACC1, ack SHALL move to ACC2 if split, else to RESP; from ACC2, ack SHALL move to RESP; with no ack the state SHALL hold.
REQ-020 bus_req SHALL stay high across the ACC1->ACC2 transition and SHALL be 0 in RESP and IDLE.
REQ-021 For loads, bus_rdata SHALL be latched on each ack into L (ACC1 into L[31:0], ACC2 into L[63:32]); rdata SHALL be the low n bytes of L>>(8*o), sign- or zero-extended to 32 bits.
REQ-022 resp_valid SHALL be 1 for exactly one cycle, in RESP; RESP SHALL then go to IDLE.
REQ-023 rdata SHALL be 0 for stores and SHALL hold its value outside RESP.
REQ-024 Latency: an aligned access acked in its first bus cycle SHALL give resp_valid 2 cycles after acceptance; a split access with immediate acks SHALL give it 3 cycles after; each stall cycle SHALL add one.
REQ-025 The block SHALL NOT accept a new request while RESP is active; back-to-back throughput SHALL be one request per 3 cycles minimum.

Reset
REQ-026 On any edge with reset=1, the block SHALL go to IDLE and SHALL clear bus_req, bus_we, bus_addr, bus_be, bus_wdata, resp_valid, rdata and L to 0; req_ready SHALL be 0 while reset=1.
REQ-027 Reset during ACC1, ACC2 or RESP SHALL abort the access with no resp_valid; bus_req SHALL be 0 from the following cycle, and a bus_ack arriving in the reset cycle SHALL be ignored.

Verification
REQ-028 Load word, mem_width=010, addr=0x100, bus_rdata=0xDEADBEEF, ack immediate -> one bus access with be=1111 and addr 0x100; rdata=0xDEADBEEF; resp_valid 2 cycles after acceptance.
REQ-029 Load byte signed, mem_width=000, addr=0x103, bus_rdata=0x80000000 -> be=1000, rdata=0xFFFFFF80; repeat with mem_width=100 -> rdata=0x00000080.
REQ-030 Split store word, mem_width=010, addr=0x102, wdata=0xAABBCCDD -> access 1 at addr 0x100, be=1100, bus_wdata=0xCCDD0000; access 2 at addr 0x104, be=0011, bus_wdata=0x0000AABB; resp_valid with rdata=0.
REQ-031 Split halfword load, mem_width=001, addr=0xFFFFFFFF, reads 0x12000000 then 0x00000034 -> second access at addr 0x00000000; rdata=0x00003412.
REQ-032 Stall then reset: bus_ack held 0 for 5 cycles, then reset asserted in ACC1 -> bus outputs stable during the stall; after reset, bus_req=0, resp_valid never pulses, req_ready=1 in the first cycle after reset deasserts.
